// File: rtl/wptr_full.sv
// Write-side pointer and full-flag generator for a dual-clock FIFO.
// Keeps the binary write address and the Gray write pointer. Brings the
// reader's Gray pointer into wclk through a two-flop synchronizer, and
// derives registered full, almost-full, fill level and a sticky overflow
// flag from the two pointers.
module wptr_full #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic                woverflow_clr,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int DEPTH = 1 << ADDRSIZE;

    // The free-slot count uses one extra bit so that DEPTH - level cannot
    // wrap, even when the threshold is DEPTH itself.
    localparam logic [ADDRSIZE+1:0] DEPTH_X  = (ADDRSIZE+2)'(DEPTH);
    localparam logic [ADDRSIZE+1:0] THRESH_X = (ADDRSIZE+2)'(AFULL_THRESH);

    logic [ADDRSIZE:0]   wbin;
    logic [ADDRSIZE:0]   wbnext;
    logic [ADDRSIZE:0]   wgnext;
    logic [ADDRSIZE:0]   wq1_rptr;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic [ADDRSIZE:0]   rbin_s;
    logic [ADDRSIZE:0]   lvl_next;
    logic [ADDRSIZE:0]   full_cmp;
    logic [ADDRSIZE+1:0] free_next;
    logic                wfull_next;
    logic                wafull_next;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above it, starting from the MSB.
    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // A write is dropped while full, so the pointers hold.
    assign wen    = winc & ~wfull;
    assign waddr  = wbin[ADDRSIZE-1:0];

    assign wbnext = wbin + {{ADDRSIZE{1'b0}}, wen};
    assign wgnext = (wbnext >> 1) ^ wbnext;

    // Only the second synchronizer stage is used. Occupancy is therefore
    // judged against a read pointer up to two edges old, which can only
    // overstate it.
    assign rbin_s   = gray2bin(wq2_rptr);
    assign lvl_next = wbnext - rbin_s;

    // Full means the writer is one lap ahead: in Gray code that is the two
    // MSBs inverted and the rest equal. The extra MSB keeps a wrapped
    // pointer from looking like full.
    assign full_cmp   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    assign wfull_next = (wgnext == full_cmp);

    // At full the free count is zero, so full always implies almost-full.
    assign free_next   = DEPTH_X - {1'b0, lvl_next};
    assign wafull_next = (free_next <= THRESH_X);

    // Two-flop synchronizer bringing the read pointer into wclk.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wq1_rptr <= '0;
            wq2_rptr <= '0;
        end else begin
            wq1_rptr <= rptr;
            wq2_rptr <= wq1_rptr;
        end
    end

    // Binary address and Gray pointer advance together on every accepted write.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin <= '0;
            wptr <= '0;
        end else begin
            wbin <= wbnext;
            wptr <= wgnext;
        end
    end

    // Registered status flags and level. For overflow, a set in the same
    // cycle as a clear wins.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wfull     <= 1'b0;
            wafull    <= 1'b0;
            wlevel    <= '0;
            woverflow <= 1'b0;
        end else begin
            wfull     <= wfull_next;
            wafull    <= wafull_next;
            wlevel    <= lvl_next;
            woverflow <= (winc & wfull) | (woverflow & ~woverflow_clr);
        end
    end

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full (ADDRSIZE=4, AFULL_THRESH=2).
// The reference model counts accepted writes and reads as plain integers and
// delays the read count by two edges. Its expected results go into a
// scoreboard queue when each cycle is driven, and are popped and compared
// after the edge.
module tb_wptr_full;

    logic       wclk = 1'b0;
    logic       wrst = 1'b0;
    logic       winc = 1'b0;
    logic [4:0] rptr = '0;
    logic       woverflow_clr = 1'b0;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       wafull;
    logic [4:0] wlevel;
    logic       woverflow;

    wptr_full #(.ADDRSIZE(4), .AFULL_THRESH(2)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .rptr(rptr),
        .woverflow_clr(woverflow_clr), .wen(wen), .waddr(waddr),
        .wptr(wptr), .wfull(wfull), .wafull(wafull), .wlevel(wlevel),
        .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct packed {
        logic       wen;
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic [4:0] wlevel;
        logic       wfull;
        logic       wafull;
        logic       woverflow;
    } rec_t;

    rec_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // reference model state (integer counts since last reset)
    int   m_wr = 0;
    int   m_rd1 = 0;
    int   m_rd2 = 0;
    logic m_full = 1'b0;
    logic m_ovf = 1'b0;

    // wen and waddr are sampled just before the edge of the cycle they belong to
    logic       pre_wen;
    logic [3:0] pre_waddr;

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    function automatic rec_t observed();
        rec_t o;
        o = {pre_wen, pre_waddr, wptr, wlevel, wfull, wafull, woverflow};
        return o;
    endfunction

    // Drive one cycle: rdc is the absolute read count whose Gray code goes on rptr.
    task automatic drive(input logic inc, input int rdc, input logic clr, input logic rst);
        rec_t e;
        int   wr_n;
        int   lvl;
        logic afull;
        logic ovf_n;
        winc = inc;
        rptr = gray5(rdc);
        woverflow_clr = clr;
        wrst = rst;
        #1;
        pre_wen   = wen;
        pre_waddr = waddr;
        e.wen   = inc & ~m_full;
        e.waddr = 4'(m_wr);
        if (rst) begin
            m_wr = 0; m_rd1 = 0; m_rd2 = 0; m_full = 1'b0; m_ovf = 1'b0;
            lvl = 0; afull = 1'b0;
        end else begin
            wr_n   = m_wr + ((inc && !m_full) ? 1 : 0);
            lvl    = wr_n - m_rd2;
            ovf_n  = (inc && m_full) || (m_ovf && !clr);
            m_full = (lvl == 16);
            afull  = ((16 - lvl) <= 2);
            m_ovf  = ovf_n;
            m_rd2  = m_rd1;
            m_rd1  = rdc;
            m_wr   = wr_n;
        end
        e.wptr      = gray5(m_wr);
        e.wlevel    = 5'(lvl);
        e.wfull     = m_full;
        e.wafull    = afull;
        e.woverflow = m_ovf;
        sb.push_back(e);
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        rec_t e, o;
        // first edge brings the DUT out of X; nothing is predicted for it
        wrst = 1'b1; winc = 1'b1; rptr = 5'b00110; woverflow_clr = 1'b0;
        @(posedge wclk);
        #1;
        drive(1'b1, 4, 1'b0, 1'b1);
        e = sb.pop_front(); o = observed(); n_total++;
        if (o !== e) $display("FAIL reset_sb got %h want %h", o, e); else n_pass++;
        n_total++;
        if ({wptr, waddr, wlevel, wfull, wafull, woverflow} !== 19'd0)
            $display("FAIL reset_state got wptr=%b waddr=%0d wlevel=%0d wfull=%b wafull=%b wovf=%b want all 0",
                     wptr, waddr, wlevel, wfull, wafull, woverflow);
        else n_pass++;
    endtask

    task automatic test_fill();
        rec_t e, o;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 0, 1'b0, 1'b0);
            e = sb.pop_front(); o = observed(); n_total++;
            if (o !== e) $display("FAIL fill_sb[%0d] got %h want %h", i, o, e); else n_pass++;
            n_total++;
            if (pre_waddr !== 4'(i - 1)) $display("FAIL fill_waddr[%0d] got %0d want %0d", i, pre_waddr, i - 1);
            else n_pass++;
            if (i == 13) begin
                n_total++;
                if (wafull !== 1'b0) $display("FAIL fill_wafull13 got %b want 0", wafull); else n_pass++;
            end
            if (i == 14) begin
                n_total++;
                if (wafull !== 1'b1 || wlevel !== 5'd14)
                    $display("FAIL fill_wafull14 got wafull=%b wlevel=%0d want 1/14", wafull, wlevel);
                else n_pass++;
            end
            if (i == 15) begin
                n_total++;
                if (wfull !== 1'b0) $display("FAIL fill_wfull15 got %b want 0", wfull); else n_pass++;
            end
        end
        n_total++;
        if (wfull !== 1'b1 || wlevel !== 5'd16 || wptr !== 5'b11000 || wen !== 1'b0)
            $display("FAIL fill_full got wfull=%b wlevel=%0d wptr=%b wen=%b want 1/16/11000/0",
                     wfull, wlevel, wptr, wen);
        else n_pass++;
    endtask

    task automatic test_overflow();
        rec_t e, o;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, 1'b0, 1'b0);
            e = sb.pop_front(); o = observed(); n_total++;
            if (o !== e) $display("FAIL ovf_sb[%0d] got %h want %h", i, o, e); else n_pass++;
        end
        n_total++;
        if (wptr !== 5'b11000 || woverflow !== 1'b1)
            $display("FAIL ovf_set got wptr=%b wovf=%b want 11000/1", wptr, woverflow);
        else n_pass++;
        drive(1'b0, 0, 1'b1, 1'b0);
        e = sb.pop_front(); o = observed(); n_total++;
        if (o !== e) $display("FAIL ovf_clr_sb got %h want %h", o, e); else n_pass++;
        n_total++;
        if (woverflow !== 1'b0) $display("FAIL ovf_clr got %b want 0", woverflow); else n_pass++;
        drive(1'b1, 0, 1'b1, 1'b0);
        e = sb.pop_front(); o = observed(); n_total++;
        if (o !== e) $display("FAIL ovf_setclr_sb got %h want %h", o, e); else n_pass++;
        n_total++;
        if (woverflow !== 1'b1) $display("FAIL ovf_set_wins got %b want 1", woverflow); else n_pass++;
    endtask

    task automatic test_drain();
        rec_t e, o;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 4, 1'b0, 1'b0);
            e = sb.pop_front(); o = observed(); n_total++;
            if (o !== e) $display("FAIL drain_sb[%0d] got %h want %h", i, o, e); else n_pass++;
            if (i < 3) begin
                n_total++;
                if (wfull !== 1'b1) $display("FAIL drain_hold[%0d] got wfull=%b want 1", i, wfull); else n_pass++;
            end
        end
        n_total++;
        if (wfull !== 1'b0 || wlevel !== 5'd12 || wafull !== 1'b0)
            $display("FAIL drain_release got wfull=%b wlevel=%0d wafull=%b want 0/12/0", wfull, wlevel, wafull);
        else n_pass++;
    endtask

    task automatic test_wrap();
        rec_t e, o;
        logic [4:0] prev;
        logic saw_wrap;
        logic saw_full;
        int rdc;
        saw_wrap = 1'b0;
        saw_full = 1'b0;
        drive(1'b0, 0, 1'b1, 1'b1);
        e = sb.pop_front(); o = observed(); n_total++;
        if (o !== e) $display("FAIL wrap_rst_sb got %h want %h", o, e); else n_pass++;
        prev = wptr;
        for (int i = 0; i < 40; i++) begin
            // reader trails by three, counting the write going in this cycle
            rdc = (m_wr + 1 >= 3) ? (m_wr + 1 - 3) : 0;
            drive(1'b1, rdc, 1'b0, 1'b0);
            e = sb.pop_front(); o = observed(); n_total++;
            if (o !== e) $display("FAIL wrap_sb[%0d] got %h want %h", i, o, e); else n_pass++;
            if (prev == 5'b10000 && wptr == 5'b00000) saw_wrap = 1'b1;
            if (wfull) saw_full = 1'b1;
            prev = wptr;
        end
        n_total++;
        if (saw_wrap !== 1'b1 || saw_full !== 1'b0)
            $display("FAIL wrap_cross got wrap=%b anyfull=%b want 1/0", saw_wrap, saw_full);
        else n_pass++;
        n_total++;
        if (wlevel !== 5'd5) $display("FAIL wrap_level got %0d want 5", wlevel); else n_pass++;
    endtask

    task automatic test_reset_mid();
        rec_t e, o;
        drive(1'b0, 0, 1'b0, 1'b1);
        e = sb.pop_front(); o = observed(); n_total++;
        if (o !== e) $display("FAIL mid_pre_sb got %h want %h", o, e); else n_pass++;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 0, 1'b0, 1'b0);
            e = sb.pop_front(); o = observed(); n_total++;
            if (o !== e) $display("FAIL mid_wr_sb[%0d] got %h want %h", i, o, e); else n_pass++;
        end
        drive(1'b1, 0, 1'b0, 1'b1);
        e = sb.pop_front(); o = observed(); n_total++;
        if (o !== e) $display("FAIL mid_rst_sb got %h want %h", o, e); else n_pass++;
        n_total++;
        if ({wptr, waddr, wlevel, wfull, wafull, woverflow} !== 19'd0)
            $display("FAIL mid_rst_state got wptr=%b waddr=%0d wlevel=%0d want all 0", wptr, waddr, wlevel);
        else n_pass++;
        drive(1'b1, 0, 1'b0, 1'b0);
        e = sb.pop_front(); o = observed(); n_total++;
        if (o !== e) $display("FAIL mid_first_sb got %h want %h", o, e); else n_pass++;
        n_total++;
        if (pre_waddr !== 4'd0 || wptr !== 5'b00001)
            $display("FAIL mid_first_wr got waddr=%0d wptr=%b want 0/00001", pre_waddr, wptr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
